// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - program counter and instruction-fetch sequencer
// Owns the fetch address, handshakes with instruction memory and presents words to decode.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_ADDRESS = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        shouldUseNewPC,
  input  logic [31:0] branchTo,
  output logic        imemRequest,
  output logic [31:0] imemAddress,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic        instructionValid,
  input  logic        instructionReady,
  output logic [31:0] instruction,
  output logic [31:0] pcAddress
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      state;
  state_t      nextState;
  logic [31:0] fetchAddress;
  logic [31:0] pendingTarget;
  logic [31:0] instructionReg;
  logic [31:0] pcReg;
  logic [31:0] target;

  // The branch unit pre-subtracts 4, so the real target is base + 4.
  assign target = {branchTo[31:2], 2'b00} + 32'd4;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= BOOT;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      BOOT:  nextState = REQ;
      REQ: begin
        if (imemAck) begin
          nextState = shouldUseNewPC ? REQ : HOLD;
        end else if (shouldUseNewPC) begin
          nextState = FLUSH;
        end
      end
      FLUSH: begin
        if (imemAck) begin
          nextState = REQ;
        end
      end
      HOLD: begin
        if (shouldUseNewPC || instructionReady) begin
          nextState = REQ;
        end
      end
      default: nextState = BOOT;
    endcase
  end

  always_comb begin
    imemRequest      = 1'b0;
    instructionValid = 1'b0;
    case (state)
      REQ:     imemRequest      = 1'b1;
      FLUSH:   imemRequest      = 1'b1;
      HOLD:    instructionValid = 1'b1;
      default: ;
    endcase
  end

  assign imemAddress = fetchAddress;
  assign instruction = instructionReg;
  assign pcAddress   = pcReg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetchAddress   <= RESET_ADDRESS;
      pendingTarget  <= 32'd0;
      instructionReg <= 32'd0;
      pcReg          <= RESET_ADDRESS;
    end else begin
      case (state)
        BOOT: begin
          if (shouldUseNewPC) begin
            fetchAddress <= target;
          end
        end
        REQ: begin
          if (imemAck && !shouldUseNewPC) begin
            instructionReg <= imemData;
            pcReg          <= fetchAddress;
            fetchAddress   <= fetchAddress + 32'd4;
          end else if (imemAck) begin
            fetchAddress <= target;
          end else if (shouldUseNewPC) begin
            pendingTarget <= target;
          end
        end
        FLUSH: begin
          // The outstanding word is dropped; the newest redirect wins.
          if (imemAck) begin
            fetchAddress <= shouldUseNewPC ? target : pendingTarget;
          end else if (shouldUseNewPC) begin
            pendingTarget <= target;
          end
        end
        HOLD: begin
          if (shouldUseNewPC) begin
            fetchAddress <= target;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;

  localparam logic [31:0] RST_ADDR = 32'h0040_0000;
  localparam logic [31:0] KEY      = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic        shouldUseNewPC;
  logic [31:0] branchTo;
  logic        imemRequest;
  logic [31:0] imemAddress;
  logic        imemAck;
  logic [31:0] imemData;
  logic        instructionValid;
  logic        instructionReady;
  logic [31:0] instruction;
  logic [31:0] pcAddress;

  int tests;
  int failed;

  fetch_pc_unit #(.RESET_ADDRESS(RST_ADDR)) dut (
    .clk              (clk),
    .rst              (rst),
    .shouldUseNewPC   (shouldUseNewPC),
    .branchTo         (branchTo),
    .imemRequest      (imemRequest),
    .imemAddress      (imemAddress),
    .imemAck          (imemAck),
    .imemData         (imemData),
    .instructionValid (instructionValid),
    .instructionReady (instructionReady),
    .instruction      (instruction),
    .pcAddress        (pcAddress)
  );

  // Memory returns a word derived from its address so each word is identifiable.
  assign imemData = imemAddress ^ KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_req(input string tag, input logic [31:0] addr);
    check({tag, ".req"}, {31'd0, imemRequest}, 32'd1);
    check({tag, ".addr"}, imemAddress, addr);
    check({tag, ".valid"}, {31'd0, instructionValid}, 32'd0);
  endtask

  task automatic expect_hold(input string tag, input logic [31:0] pc);
    check({tag, ".valid"}, {31'd0, instructionValid}, 32'd1);
    check({tag, ".req"}, {31'd0, imemRequest}, 32'd0);
    check({tag, ".pc"}, pcAddress, pc);
    check({tag, ".instr"}, instruction, pc ^ KEY);
  endtask

  initial begin
    tests            = 0;
    failed           = 0;
    rst              = 1'b0;
    shouldUseNewPC   = 1'b0;
    branchTo         = 32'd0;
    imemAck          = 1'b1;
    instructionReady = 1'b1;
    tick();
    tick();
    check("rst.req", {31'd0, imemRequest}, 32'd0);
    check("rst.valid", {31'd0, instructionValid}, 32'd0);
    check("rst.instr", instruction, 32'd0);
    check("rst.pc", pcAddress, RST_ADDR);
    check("rst.addr", imemAddress, RST_ADDR);

    // Streaming with ack and ready tied high: REQ/HOLD alternate.
    rst = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      expect_req("seq", RST_ADDR + 32'(4 * i));
      tick();
      expect_hold("seq", RST_ADDR + 32'(4 * i));
      tick();
    end

    // Redirect coincident with ack lands at 0x100, then stall in HOLD.
    shouldUseNewPC   = 1'b1;
    branchTo         = 32'h0000_00FC;
    instructionReady = 1'b0;
    tick();
    expect_req("to100", 32'h100);
    shouldUseNewPC = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      expect_hold("stall", 32'h100);
      tick();
    end
    expect_hold("stall", 32'h100);
    shouldUseNewPC = 1'b1;
    branchTo       = 32'h0000_01FC;
    tick();
    expect_req("hold_redir", 32'h200);
    shouldUseNewPC   = 1'b0;
    instructionReady = 1'b1;
    tick();
    expect_hold("at200", 32'h200);

    // Back to 0x100, then REQ at 0x104 waiting for a late ack.
    shouldUseNewPC = 1'b1;
    branchTo       = 32'h0000_00FC;
    tick();
    expect_req("back100", 32'h100);
    shouldUseNewPC = 1'b0;
    tick();
    expect_hold("back100", 32'h100);
    imemAck = 1'b0;
    tick();
    expect_req("wait104", 32'h104);
    shouldUseNewPC = 1'b1;
    branchTo       = 32'h0000_03FC;
    tick();
    shouldUseNewPC = 1'b0;
    for (int i = 0; i < 2; i++) begin
      expect_req("flush", 32'h104);
      tick();
    end
    expect_req("flush", 32'h104);
    imemAck = 1'b1;
    tick();
    expect_req("after_flush", 32'h400);
    tick();
    expect_hold("at400", 32'h400);
    tick();
    expect_req("req404", 32'h404);

    // Redirect on the same edge as the ack: word discarded.
    shouldUseNewPC = 1'b1;
    branchTo       = 32'h0000_07FC;
    tick();
    expect_req("ack_redir", 32'h800);
    shouldUseNewPC = 1'b0;
    tick();
    expect_hold("at800", 32'h800);

    // Address wrap past the top of memory.
    shouldUseNewPC = 1'b1;
    branchTo       = 32'hFFFF_FFF8;
    tick();
    expect_req("top", 32'hFFFF_FFFC);
    shouldUseNewPC = 1'b0;
    tick();
    expect_hold("top", 32'hFFFF_FFFC);
    tick();
    expect_req("wrap", 32'h0000_0000);
    tick();
    expect_hold("wrap", 32'h0000_0000);

    // Low bits of branchTo are ignored.
    shouldUseNewPC = 1'b1;
    branchTo       = 32'h0000_0203;
    tick();
    expect_req("unaligned", 32'h204);
    shouldUseNewPC = 1'b0;

    // Reset while a flushed request is outstanding.
    imemAck        = 1'b0;
    shouldUseNewPC = 1'b1;
    branchTo       = 32'h0000_0050;
    tick();
    expect_req("pre_rst_flush", 32'h204);
    shouldUseNewPC = 1'b0;
    rst            = 1'b0;
    tick();
    check("rst2.req", {31'd0, imemRequest}, 32'd0);
    check("rst2.valid", {31'd0, instructionValid}, 32'd0);
    check("rst2.instr", instruction, 32'd0);
    check("rst2.pc", pcAddress, RST_ADDR);
    check("rst2.addr", imemAddress, RST_ADDR);
    rst     = 1'b1;
    imemAck = 1'b1;
    tick();
    expect_req("reboot", RST_ADDR);
    tick();
    expect_hold("reboot", RST_ADDR);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program counter and instruction-fetch sequencer that consumes the branch unit's redirect (`shouldUseNewPC`, `branchTo`). It owns the fetch address, runs a request/acknowledge handshake with instruction memory, and hands each fetched word with its address (`pcAddress`) to decode through a valid/ready handshake. The same `pcAddress` feeds back into the branch unit.

## Interface
- `RESET_ADDRESS`, default 32'h0000_0000: first fetch address after reset; must be word aligned.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-low.
- `shouldUseNewPC` input 1: redirect strobe from the branch unit; sampled every cycle.
- `branchTo` input 32: redirect base; meaningful only while `shouldUseNewPC`=1.
- `imemRequest` output 1: fetch request to instruction memory.
- `imemAddress` output 32: word address of the current request.
- `imemAck` input 1: memory has `imemData` valid this cycle; ignored unless `imemRequest`=1.
- `imemData` input 32: fetched instruction word.
- `instructionValid` output 1: `instruction` and `pcAddress` are valid for decode.
- `instructionReady` input 1: decode accepts the held instruction.
- `instruction` output 32: held instruction word.
- `pcAddress` output 32: address of the held instruction.

## Operation
- States:
  - BOOT: one cycle after reset, no request.
  - REQ: request outstanding.
  - FLUSH: request outstanding whose data will be discarded.
  - HOLD: instruction presented to decode.
- Registers:
  - `fetchAddress`: drives `imemAddress`.
  - `pendingTarget`: captured redirect.
  - Output holding registers for `instruction` and `pcAddress`.
- Redirect target is `{branchTo[31:2], 2'b00} + 32'd4`. The branch unit pre-compensates for this +4. Address bits [1:0] are always 0. All sums are modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0.
- BOOT:
  - Redirect present: `fetchAddress` ← target.
  - Always → REQ.
- REQ: `imemRequest`=1, and `imemAddress` stays stable until ack.
  - Ack, no redirect: `instruction` ← `imemData`, `pcAddress` ← `fetchAddress`, `fetchAddress` += 4, → HOLD.
  - Ack with same-cycle redirect: discard data, `fetchAddress` ← target, stay REQ. The new request address appears the next cycle.
  - No ack, redirect: `pendingTarget` ← target, → FLUSH.
- FLUSH: `imemRequest`=1 on the old address.
  - A later redirect overwrites `pendingTarget`; the last one wins.
  - On ack: discard data, `fetchAddress` ← `pendingTarget` (or the same-cycle target), → REQ.
- HOLD: `instructionValid`=1.
  - Redirect (has priority over ready): `instructionValid` drops, `fetchAddress` ← target, → REQ.
  - `instructionReady`=1, no redirect: → REQ.
  - `instructionReady`=0: hold all outputs unchanged.
- `instructionValid`=1 only in HOLD. No instruction fetched before a redirect is ever presented after that redirect.
- Reset (`rst`=0 at an edge), in any state including mid-request:
  - → BOOT.
  - `imemRequest`=0, `instructionValid`=0, `instruction`=0.
  - `fetchAddress`=`pcAddress`=`RESET_ADDRESS`, `pendingTarget`=0.
  - Memory must tolerate an abandoned request.

## Timing
- Outputs are registered, except `imemRequest`, `instructionValid` and `imemAddress`, which are decoded from state and registers only (no input-to-output combinational path).
- Ack may arrive in the first REQ cycle. Minimum interval from entering REQ to `instructionValid`=1 is 1 cycle.
- Peak throughput is one instruction per 2 cycles (REQ, HOLD).
- First request is asserted 1 cycle after `rst` deasserts (BOOT).
- Redirect-to-new-request latency:
  - From HOLD or REQ+ack: 1 cycle.
  - From REQ without ack: the outstanding ack, then 1 cycle.

## Test plan
- Reset, `RESET_ADDRESS`=32'h0040_0000, `imemAck` tied 1, `instructionReady` tied 1 -> requests to 0x400000, 0x400004, 0x400008 on alternating cycles; `pcAddress` matches each word returned.
- In HOLD at `pcAddress`=0x100, `instructionReady`=0 for 5 cycles -> outputs frozen, no request. Then `shouldUseNewPC`=1, `branchTo`=0x1FC -> next request to 0x200, `instructionValid`=0 meanwhile.
- Redirect `branchTo`=0x3FC while REQ is waiting on ack at 0x104, ack delayed 3 cycles -> data for 0x104 never presented; next request to 0x400.
- Redirect coincident with ack in REQ (`branchTo`=0x7FC) -> returned word discarded; request to 0x800 the following cycle.
- Fetch at 32'hFFFF_FFFC acked -> next request to 32'h0000_0000. Separately, `branchTo`=0x203 -> request 0x204.
- `rst`=0 asserted while FLUSH is outstanding -> `imemRequest`=0 next edge; after release, one BOOT cycle, then a request to `RESET_ADDRESS`.
